// File: rtl/fft_frame_loader.sv
// Forward-transform driver for the shared fft core: fills one frame of real
// samples, launches the core, then streams the complex bins out with their index.
module fft_frame_loader #(
   parameter int NB        = 18,
   parameter int LOG_DEPTH = 9
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NB-1:0]          sample_in,
   input  logic                   sample_valid,
   output logic [2*NB-1:0]        bin_data,
   output logic [LOG_DEPTH-1:0]   bin_addr,
   output logic                   bin_valid,
   input  logic                   bin_ready,
   output logic                   frame_done,
   output logic [3:0]             frame_scaling,
   output logic                   overrun,
   input  logic                   ctl_ready,
   output logic                   ctl_start,
   output logic [3:0]             ctl_log_depth,
   output logic                   ctl_real_mode,
   output logic                   ctl_direction,
   input  logic                   ctl_done,
   input  logic [3:0]             ctl_output_scaling,
   output logic [LOG_DEPTH-1:0]   data_address,
   output logic                   data_write_enable,
   output logic [2*NB-1:0]        data_write_data,
   output logic                   data_read_enable,
   input  logic                   data_read_valid,
   input  logic [2*NB-1:0]        data_read_data
);

   localparam logic [LOG_DEPTH-1:0] LAST = {LOG_DEPTH{1'b1}};

   typedef enum logic [1:0] {FILL, START, WAIT_DONE, READ} state_t;

   state_t               state, next_state;
   logic [LOG_DEPTH-1:0] fill_cnt, rd_cnt, wr_addr;
   logic                 rd_pending;
   logic                 bin_accept;

   assign bin_accept    = bin_valid && bin_ready;
   assign ctl_log_depth = 4'(LOG_DEPTH);
   assign ctl_real_mode = 1'b0;
   assign ctl_direction = 1'b0;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) state <= FILL;
      else       state <= next_state;
   end

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      next_state = state;
      case (state)
         FILL:      if (sample_valid && fill_cnt == LAST) next_state = START;
         START:     if (ctl_ready && !data_write_enable) next_state = WAIT_DONE;
         WAIT_DONE: if (ctl_done) next_state = READ;
         READ:      if (bin_accept && rd_cnt == LAST) next_state = FILL;
         default:   next_state = FILL;
      endcase
   end

   // The last sample's write lands in START, so the start pulse waits for it.
   always_comb begin
      ctl_start    = 1'b0;
      data_address = '0;
      case (state)
         FILL:    data_address = fill_cnt;
         START:   ctl_start = ctl_ready && !data_write_enable;
         READ:    data_address = rd_cnt;
         default: ;
      endcase
      if (data_write_enable) data_address = wr_addr;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fill_cnt          <= '0;
         rd_cnt            <= '0;
         wr_addr           <= '0;
         rd_pending        <= 1'b0;
         data_write_enable <= 1'b0;
         data_write_data   <= '0;
         data_read_enable  <= 1'b0;
         bin_valid         <= 1'b0;
         bin_data          <= '0;
         bin_addr          <= '0;
         frame_done        <= 1'b0;
         frame_scaling     <= '0;
         overrun           <= 1'b0;
      end else begin
         data_write_enable <= 1'b0;
         data_read_enable  <= 1'b0;
         frame_done        <= 1'b0;

         if (sample_valid) begin
            if (state == FILL) begin
               data_write_enable <= 1'b1;
               data_write_data   <= {{NB{1'b0}}, sample_in};
               wr_addr           <= fill_cnt;
               fill_cnt          <= (fill_cnt == LAST) ? '0 : fill_cnt + 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end

         case (state)
            WAIT_DONE: begin
               if (ctl_done) begin
                  frame_scaling    <= ctl_output_scaling;
                  rd_cnt           <= '0;
                  data_read_enable <= 1'b1;
                  rd_pending       <= 1'b1;
               end
            end
            READ: begin
               // Core returns {imag, real}; consumers expect real in the high half.
               if (rd_pending && data_read_valid) begin
                  bin_data   <= {data_read_data[NB-1:0], data_read_data[2*NB-1:NB]};
                  bin_addr   <= rd_cnt;
                  bin_valid  <= 1'b1;
                  rd_pending <= 1'b0;
               end
               if (bin_accept) begin
                  bin_valid <= 1'b0;
                  if (rd_cnt == LAST) begin
                     frame_done <= 1'b1;
                     rd_cnt     <= '0;
                  end else begin
                     rd_cnt           <= rd_cnt + 1'b1;
                     data_read_enable <= 1'b1;
                     rd_pending       <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Bench for fft_frame_loader: behavioural fft-core stand-in plus a frame-level
// model of expected writes and bins, driven by a table of frame scenarios.
`timescale 1ns/1ps
module tb_fft_frame_loader;

   localparam int NB        = 18;
   localparam int LOG_DEPTH = 9;
   localparam int N         = 1 << LOG_DEPTH;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NB-1:0]        sample_in;
   logic                 sample_valid;
   logic [2*NB-1:0]      bin_data;
   logic [LOG_DEPTH-1:0] bin_addr;
   logic                 bin_valid;
   logic                 bin_ready;
   logic                 frame_done;
   logic [3:0]           frame_scaling;
   logic                 overrun;
   logic                 ctl_ready;
   logic                 ctl_start;
   logic [3:0]           ctl_log_depth;
   logic                 ctl_real_mode;
   logic                 ctl_direction;
   logic                 ctl_done;
   logic [3:0]           ctl_output_scaling;
   logic [LOG_DEPTH-1:0] data_address;
   logic                 data_write_enable;
   logic [2*NB-1:0]      data_write_data;
   logic                 data_read_enable;
   logic                 data_read_valid;
   logic [2*NB-1:0]      data_read_data;

   always #5 clk = ~clk;

   fft_frame_loader #(.NB(NB), .LOG_DEPTH(LOG_DEPTH)) dut (
      .clk(clk), .reset(reset),
      .sample_in(sample_in), .sample_valid(sample_valid),
      .bin_data(bin_data), .bin_addr(bin_addr), .bin_valid(bin_valid), .bin_ready(bin_ready),
      .frame_done(frame_done), .frame_scaling(frame_scaling), .overrun(overrun),
      .ctl_ready(ctl_ready), .ctl_start(ctl_start), .ctl_log_depth(ctl_log_depth),
      .ctl_real_mode(ctl_real_mode), .ctl_direction(ctl_direction),
      .ctl_done(ctl_done), .ctl_output_scaling(ctl_output_scaling),
      .data_address(data_address), .data_write_enable(data_write_enable),
      .data_write_data(data_write_data), .data_read_enable(data_read_enable),
      .data_read_valid(data_read_valid), .data_read_data(data_read_data)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct packed {
      logic [LOG_DEPTH-1:0] addr;
      logic [2*NB-1:0]      data;
   } wr_t;

   typedef struct {
      bit         ramp;
      int         ready_delay;
      int         stall_bin;
      int         stall_len;
      int         ovr_strobes;
      bit         rand_mode;
      logic [3:0] scaling;
      logic       exp_overrun;
   } frame_vec_t;

   wr_t        exp_wr[$];
   logic [3:0] cur_scaling = 4'd0;
   int         start_cnt = 0;
   int         frame_done_cnt = 0;
   int         bins_seen = 0;

   // Core contents after the transform: real = index, imag = -index.
   function automatic logic [2*NB-1:0] bin_word(input int k);
      logic [NB-1:0] re, im;
      re = NB'(k);
      im = NB'(-k);
      return {re, im};
   endfunction

   // Core stand-in and monitor: observes DUT at negedge, drives core replies then.
   initial begin
      int   done_timer;
      int   rd_lat;
      int   rd_addr_q;
      int   exp_bin;
      logic prev_start, prev_hold, prev_acc, expect_fd;
      wr_t  w;
      done_timer = 0; rd_lat = 0; rd_addr_q = 0; exp_bin = 0;
      prev_start = 0; prev_hold = 0; prev_acc = 0; expect_fd = 0;
      ctl_done = 1'b0; ctl_output_scaling = 4'd0;
      data_read_valid = 1'b0; data_read_data = '0;
      forever begin
         @(negedge clk);
         ctl_done        = 1'b0;
         data_read_valid = 1'b0;
         if (done_timer > 0) begin
            done_timer--;
            if (done_timer == 0) begin
               ctl_done = 1'b1;
               ctl_output_scaling = cur_scaling;
            end else if (done_timer == 50) begin
               data_read_valid = 1'b1;
               data_read_data  = '1;
            end
         end else if (!ctl_ready) begin
            ctl_done = 1'b1;
            ctl_output_scaling = 4'hf;
         end
         if (rd_lat > 0) begin
            rd_lat--;
            if (rd_lat == 0) begin
               data_read_valid = 1'b1;
               data_read_data  = {NB'(-rd_addr_q), NB'(rd_addr_q)};
            end
         end else if (bin_valid && !bin_ready) begin
            data_read_valid = 1'b1;
            data_read_data  = '1;
         end

         if (reset) begin
            exp_bin = 0; expect_fd = 0; prev_hold = 0; prev_acc = 0; prev_start = 0;
            exp_wr.delete();
         end else begin
            if (data_write_enable) begin
               if (exp_wr.size() == 0) check("unexpected_write", 1, 0);
               else begin
                  w = exp_wr.pop_front();
                  check("wr_addr", data_address, w.addr);
                  check("wr_data", data_write_data, w.data);
               end
            end
            if (ctl_start) begin
               check("start_width", prev_start, 0);
               check("start_ready", ctl_ready, 1);
               start_cnt++;
               done_timer = 100;
            end
            prev_start = ctl_start;
            if (data_read_enable) begin
               check("one_outstanding", rd_lat != 0, 0);
               check("rd_while_valid", bin_valid, 0);
               check("rd_addr", data_address, exp_bin);
               rd_lat = 2;
               rd_addr_q = int'(data_address);
            end
            if (prev_hold) check("hold_valid", bin_valid, 1);
            if (prev_acc)  check("valid_drop", bin_valid, 0);
            if (bin_valid) begin
               check("bin_addr", bin_addr, exp_bin);
               check("bin_data", bin_data, bin_word(exp_bin));
            end
            if (frame_done || expect_fd) check("frame_done", frame_done, expect_fd);
            if (frame_done) frame_done_cnt++;
            prev_hold = bin_valid && !bin_ready;
            prev_acc  = bin_valid && bin_ready;
            expect_fd = bin_valid && bin_ready && exp_bin == N - 1;
            if (bin_valid && bin_ready) begin
               bins_seen++;
               exp_bin = (exp_bin + 1) % N;
            end
         end
      end
   end

   task automatic fill_frame(input bit ramp, input bit gaps);
      logic [NB-1:0] s;
      for (int i = 0; i < N; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            sample_valid = 1'b0;
            @(posedge clk); #1;
         end
         s = ramp ? NB'(i) : NB'($urandom);
         sample_in    = s;
         sample_valid = 1'b1;
         exp_wr.push_back({LOG_DEPTH'(i), {NB'(0), s}});
         @(posedge clk); #1;
      end
      sample_valid = 1'b0;
   endtask

   task automatic wait_start(input int s0);
      int cyc = 0;
      while (start_cnt == s0 && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("start_seen", start_cnt - s0, 1);
   endtask

   task automatic run_frame(input frame_vec_t v);
      int s0, f0, b0, cyc, stall_left;
      bit stalled;
      s0 = start_cnt; f0 = frame_done_cnt; b0 = bins_seen;
      cur_scaling = v.scaling;
      ctl_ready   = (v.ready_delay == 0);
      fill_frame(v.ramp, v.rand_mode);
      if (v.ready_delay > 0) begin
         repeat (v.ready_delay) @(posedge clk);
         #1;
         check("start_held", start_cnt - s0, 0);
         ctl_ready = 1'b1;
      end
      wait_start(s0);
      repeat (5) @(posedge clk);
      #1;
      for (int k = 0; k < v.ovr_strobes; k++) begin
         sample_in = NB'($urandom);
         sample_valid = 1'b1;
         @(posedge clk); #1;
         sample_valid = 1'b0;
         @(posedge clk); #1;
      end
      if (v.ovr_strobes > 0) check("overrun_set", overrun, 1);
      stalled = 0; stall_left = 0; cyc = 0;
      while (frame_done_cnt == f0 && cyc < 20000) begin
         if (bin_valid && int'(bin_addr) == v.stall_bin && !stalled) begin
            stalled = 1;
            stall_left = v.stall_len;
         end
         if (stall_left > 0) begin
            bin_ready = 1'b0;
            stall_left--;
         end else begin
            bin_ready = v.rand_mode ? 1'($urandom) : 1'b1;
         end
         @(posedge clk); #1;
         cyc++;
      end
      bin_ready = 1'b0;
      check("frame_done_seen", frame_done_cnt - f0, 1);
      check("bins_in_frame", bins_seen - b0, N);
      check("frame_scaling", frame_scaling, v.scaling);
      check("overrun", overrun, v.exp_overrun);
      check("start_once", start_cnt - s0, 1);
      check("writes_drained", exp_wr.size(), 0);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      frame_vec_t vec[4];
      int         cyc, f0;
      vec[0] = '{ramp: 1, ready_delay: 0,  stall_bin: -1,  stall_len: 0,  ovr_strobes: 0,
                 rand_mode: 0, scaling: 4'd5,  exp_overrun: 1'b0};
      vec[1] = '{ramp: 0, ready_delay: 50, stall_bin: 7,   stall_len: 10, ovr_strobes: 0,
                 rand_mode: 0, scaling: 4'd9,  exp_overrun: 1'b0};
      vec[2] = '{ramp: 0, ready_delay: 0,  stall_bin: -1,  stall_len: 0,  ovr_strobes: 3,
                 rand_mode: 1, scaling: 4'd2,  exp_overrun: 1'b1};
      vec[3] = '{ramp: 0, ready_delay: 5,  stall_bin: 300, stall_len: 4,  ovr_strobes: 0,
                 rand_mode: 1, scaling: 4'd12, exp_overrun: 1'b1};

      reset = 1'b1; sample_in = '0; sample_valid = 1'b0; bin_ready = 1'b0; ctl_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_bin_valid", bin_valid, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_write_en", data_write_enable, 0);
      check("rst_read_en", data_read_enable, 0);
      check("rst_ctl_start", ctl_start, 0);
      check("rst_overrun", overrun, 0);
      check("rst_scaling", frame_scaling, 0);
      check("rst_bin_data", bin_data, 0);
      check("rst_bin_addr", bin_addr, 0);
      check("rst_address", data_address, 0);
      check("log_depth", ctl_log_depth, LOG_DEPTH);
      check("real_mode", ctl_real_mode, 0);
      check("direction", ctl_direction, 0);
      reset = 1'b0;

      for (int i = 0; i < 4; i++) run_frame(vec[i]);

      // Reset while streaming bin 200: frame is abandoned without frame_done.
      f0 = frame_done_cnt;
      cur_scaling = 4'd3;
      ctl_ready = 1'b1;
      fill_frame(1'b0, 1'b0);
      wait_start(start_cnt - 1 + 1 - 1 + 1 - 1);
      cyc = 0;
      bin_ready = 1'b1;
      while (!(bin_valid && bin_addr == LOG_DEPTH'(200)) && cyc < 5000) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("reached_bin200", bin_valid && bin_addr == LOG_DEPTH'(200), 1);
      bin_ready = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("mid_rst_bin_valid", bin_valid, 0);
      check("mid_rst_read_en", data_read_enable, 0);
      check("mid_rst_frame_done", frame_done, 0);
      check("mid_rst_overrun", overrun, 0);
      check("mid_rst_scaling", frame_scaling, 0);
      check("mid_rst_bin_addr", bin_addr, 0);
      repeat (10) @(posedge clk);
      #1;
      check("no_frame_done_after_rst", frame_done_cnt - f0, 0);

      run_frame(vec[0]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
